gate_response_checker: RTL and testbench

Synthesizable self-checking harness that acts as the checking end of the gate test flow. It drives every input combination into a small combinational gate-under-test, waits for the output to settle, and samples the gate output. It compares each sample with an expected truth table and reports pass/fail, an error count and the first failing vector. It sits beside a gate-level DUT (for example the 2-input OR gate) so the checking can run on-chip or in a bench without hand-written vectors.

---
 rtl/gate_response_checker_pkg.sv | 15 +
 rtl/gate_response_checker_settle_timer.sv | 41 ++++
 rtl/gate_response_checker.sv | 159 +++++++++++++++
 tb/tb_gate_response_checker.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_response_checker_pkg.sv
// Shared definitions for the gate response checker: FSM state encodings and
// a helper that derives the number of stimulus vectors from the input count.
package gate_response_checker_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Number of distinct input combinations for an n-input gate.
  function automatic int unsigned nvec(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

endpackage

// File: rtl/gate_response_checker_settle_timer.sv
// Settle timer: down-counter loaded with SETTLE-1. expire is high while the
// count is zero, so the stimulus is held for exactly SETTLE cycles once loaded.
module settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  // A one-cycle settle still needs a 1-bit counter.
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Load takes priority; otherwise count down while enabled, stopping at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = LOAD_VAL;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == '0);

endmodule

// File: rtl/gate_response_checker.sv
// Gate response checker: walks every input combination of a small
// combinational gate, lets each settle, samples the gate output and compares
// it against an expected truth table. Reports pass, a mismatch count and the
// first failing vector. Every output comes straight from a register.
module gate_response_checker
  import gate_response_checker_pkg::*;
#(
  parameter int                      N_IN   = 2,
  parameter logic [(2**N_IN)-1:0]    TRUTH  = (2**N_IN)'(4'b1110),
  parameter int                      SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            resp,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic            fail_valid,
  output logic [N_IN-1:0] fail_vec
);

  localparam int NVEC = nvec(N_IN);
  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NVEC - 1);

  logic [1:0]      state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   err_q, err_d;
  logic            fv_q, fv_d;
  logic [N_IN-1:0] fvec_q, fvec_d;

  logic timer_load;
  logic timer_en;
  logic timer_expire;
  logic mismatch;

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .en     (timer_en),
    .expire (timer_expire)
  );

  // Next-state logic: FSM, vector counter and scoreboard updates. Output
  // registers are updated on the transition into a state so they are valid
  // for the whole cycle the FSM spends there.
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    stim_d     = stim_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    err_d      = err_q;
    fv_d       = fv_q;
    fvec_d     = fvec_q;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    mismatch   = (resp != TRUTH[vec_q]);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_DRIVE;
          vec_d      = '0;
          stim_d     = '0;
          busy_d     = 1'b1;
          pass_d     = 1'b0;
          err_d      = '0;
          fv_d       = 1'b0;
          fvec_d     = '0;
          timer_load = 1'b1;
        end
      end

      ST_DRIVE: begin
        timer_en = 1'b1;
        if (timer_expire) begin
          state_d = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (!fv_q) begin
            fv_d   = 1'b1;
            fvec_d = vec_q;
          end
        end
        if (vec_q == LAST_VEC) begin
          state_d = ST_DONE;
          stim_d  = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // Uses the updated count so the last vector's verdict is included.
          pass_d  = (err_d == '0);
        end else begin
          state_d    = ST_DRIVE;
          vec_d      = vec_q + 1'b1;
          stim_d     = vec_q + 1'b1;
          timer_load = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous clear; a mid-run reset
  // aborts without producing done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fvec_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fvec_q  <= fvec_d;
    end
  end

  assign stim       = stim_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign fail_valid = fv_q;
  assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker. Three checker instances: the default
// 2-input configuration with a selectable gate (OR, stuck-at-0, AND), a
// 2-input AND checker, and a 3-input OR checker with a 1-cycle settle.
// Expected run results are computed from a gate model and queued when a run
// is started, then popped and compared when done pulses.
module tb_gate_response_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_a, start_b, start_c;
  int   mode_a;  // 0: OR, 1: stuck-at-0, 2: AND

  logic [1:0] stim_a;  logic resp_a, busy_a, done_a, pass_a, fv_a; logic [2:0] err_a; logic [1:0] fvec_a;
  logic [2:0] stim_b;  logic resp_b, busy_b, done_b, pass_b, fv_b; logic [3:0] err_b; logic [2:0] fvec_b;
  logic [1:0] stim_c;  logic resp_c, busy_c, done_c, pass_c, fv_c; logic [2:0] err_c; logic [1:0] fvec_c;

  assign resp_a = (mode_a == 0) ? (|stim_a) : (mode_a == 2) ? (&stim_a) : 1'b0;
  assign resp_b = |stim_b;
  assign resp_c = &stim_c;

  gate_response_checker u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stim(stim_a), .resp(resp_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
    .fail_valid(fv_a), .fail_vec(fvec_a)
  );

  gate_response_checker #(.N_IN(3), .TRUTH(8'hFE), .SETTLE(1)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stim(stim_b), .resp(resp_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
    .fail_valid(fv_b), .fail_vec(fvec_b)
  );

  gate_response_checker #(.N_IN(2), .TRUTH(4'b1000), .SETTLE(2)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_c), .stim(stim_c), .resp(resp_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_cnt(err_c),
    .fail_valid(fv_c), .fail_vec(fvec_c)
  );

  // Observation mux: which instance the current step is looking at.
  int sel;
  logic [2:0] o_stim; logic o_busy, o_done, o_pass, o_fv; logic [3:0] o_err; logic [2:0] o_fvec;
  always_comb begin
    o_stim = '0; o_busy = 1'b0; o_done = 1'b0; o_pass = 1'b0;
    o_fv = 1'b0; o_err = '0; o_fvec = '0;
    case (sel)
      0: begin
        o_stim = {1'b0, stim_a}; o_busy = busy_a; o_done = done_a; o_pass = pass_a;
        o_fv = fv_a; o_err = {1'b0, err_a}; o_fvec = {1'b0, fvec_a};
      end
      1: begin
        o_stim = stim_b; o_busy = busy_b; o_done = done_b; o_pass = pass_b;
        o_fv = fv_b; o_err = err_b; o_fvec = fvec_b;
      end
      default: begin
        o_stim = {1'b0, stim_c}; o_busy = busy_c; o_done = done_c; o_pass = pass_c;
        o_fv = fv_c; o_err = {1'b0, err_c}; o_fvec = {1'b0, fvec_c};
      end
    endcase
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic pass;
    int   err;
    logic fv;
    int   fvec;
    int   done_k;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic gate_fn(input int g, input int v, input int n);
    case (g)
      0:       return (v != 0);
      2:       return (v == (1 << n) - 1);
      default: return 1'b0;
    endcase
  endfunction

  function automatic int n_of(input int s);
    return (s == 1) ? 3 : 2;
  endfunction

  function automatic int settle_of(input int s);
    return (s == 1) ? 1 : 2;
  endfunction

  // Model a whole run and queue its expected outcome.
  task automatic push_expected(input int s, input int g);
    exp_t item;
    logic [7:0] tt;
    int n = n_of(s);
    int e = 0;
    int first = -1;
    tt = (s == 1) ? 8'hFE : (s == 0) ? 8'h0E : 8'h08;
    for (int v = 0; v < (1 << n); v++) begin
      if (gate_fn(g, v, n) != tt[v]) begin
        e++;
        if (first < 0) first = v;
      end
    end
    item.pass   = (e == 0);
    item.err    = e;
    item.fv     = (e != 0);
    item.fvec   = (first < 0) ? 0 : first;
    item.done_k = (1 << n) * (settle_of(s) + 1);
    sb.push_back(item);
  endtask

  task automatic check_done_pop(input int k);
    exp_t x;
    if (sb.size() == 0) begin
      check("unexpected_done", 32'd1, 32'd0);
      return;
    end
    x = sb.pop_front();
    check("done_cycle", k, x.done_k);
    check("pass", {31'd0, o_pass}, {31'd0, x.pass});
    check("err_cnt", {28'd0, o_err}, x.err);
    check("fail_valid", {31'd0, o_fv}, {31'd0, x.fv});
    check("fail_vec", {29'd0, o_fvec}, x.fvec);
    check("busy_at_done", {31'd0, o_busy}, 32'd0);
    check("stim_at_done", {29'd0, o_stim}, 32'd0);
    $display("run done sel=%0d cycle=%0d pass=%0b err_cnt=%0d fail_valid=%0b fail_vec=%0d",
             sel, k, o_pass, o_err, o_fv, o_fvec);
  endtask

  task automatic set_start(input int s, input logic v);
    case (s)
      0:       start_a = v;
      1:       start_b = v;
      default: start_c = v;
    endcase
  endtask

  // Called at a falling edge; returns at the falling edge of cycle k=0 (the
  // cycle that begins at the accepting edge E).
  task automatic pulse_start(input int s);
    set_start(s, 1'b1);
    @(negedge clk);
    set_start(s, 1'b0);
  endtask

  // One complete run, checking the stimulus sequence each cycle and the
  // result against the queued expectation when done pulses.
  task automatic run(input int s, input int g);
    int exp_k;
    int st;
    int k;
    bit got;
    sel = s;
    if (s == 0) mode_a = g;
    push_expected(s, g);
    exp_k = sb[$].done_k;
    st    = settle_of(s);
    pulse_start(s);
    k = 0;
    got = 0;
    while (!got && k <= exp_k + 3) begin
      if (o_done) begin
        check_done_pop(k);
        got = 1;
      end else begin
        if (k < exp_k) begin
          check("stim_step", {29'd0, o_stim}, k / (st + 1));
          check("busy_run", {31'd0, o_busy}, 32'd1);
        end
        @(negedge clk);
        k++;
      end
    end
    if (!got) begin
      check("done_timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    @(negedge clk);
    check("done_one_cycle", {31'd0, o_done}, 32'd0);
  endtask

  initial begin
    int dcount;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    mode_a = 0; sel = 0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_stim", {29'd0, o_stim}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    check("rst_pass", {31'd0, o_pass}, 32'd0);
    check("rst_err", {28'd0, o_err}, 32'd0);
    check("rst_fv", {31'd0, o_fv}, 32'd0);
    check("rst_fvec", {29'd0, o_fvec}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // OR gate against OR table, then stuck-at-0.
    run(0, 0);
    run(0, 1);

    // Reset in the middle of a run: immediate clear, no done.
    sel = 0; mode_a = 0;
    pulse_start(0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_stim", {29'd0, o_stim}, 32'd0);
    check("abort_busy", {31'd0, o_busy}, 32'd0);
    check("abort_pass", {31'd0, o_pass}, 32'd0);
    check("abort_err", {28'd0, o_err}, 32'd0);
    check("abort_fv", {31'd0, o_fv}, 32'd0);
    check("abort_fvec", {29'd0, o_fvec}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_done) dcount++;
    end
    check("abort_no_done", dcount, 32'd0);
    run(0, 0);

    // AND gate against OR table, AND gate against AND table, 3-input OR.
    run(0, 2);
    run(2, 2);
    run(1, 0);

    // Start pulses while busy and while in DONE are ignored.
    sel = 0; mode_a = 0;
    push_expected(0, 0);
    pulse_start(0);
    dcount = 0;
    for (int k = 0; k <= 40; k++) begin
      if (k == 2)  start_a = 1'b1;
      if (k == 3)  start_a = 1'b0;
      if (k == 11) start_a = 1'b1;
      if (k == 13) start_a = 1'b0;
      if (o_done) begin
        dcount++;
        check_done_pop(k);
      end
      @(negedge clk);
    end
    check("single_done", dcount, 32'd1);
    check("idle_after_ignored", {31'd0, o_busy}, 32'd0);

    // Start held high: back-to-back runs, results cleared at the restart.
    push_expected(0, 1);
    push_expected(0, 0);
    mode_a = 1;
    start_a = 1'b1;
    @(negedge clk);
    dcount = 0;
    for (int k = 0; k <= 30; k++) begin
      if (o_done) begin
        dcount++;
        check_done_pop((dcount == 1) ? k : k - 14);
      end
      if (k == 13) begin
        check("held_idle_busy", {31'd0, o_busy}, 32'd0);
        check("held_idle_err", {28'd0, o_err}, 32'd3);
        check("held_idle_fv", {31'd0, o_fv}, 32'd1);
        mode_a = 0;
      end
      if (k == 14) begin
        check("restart_busy", {31'd0, o_busy}, 32'd1);
        check("restart_err", {28'd0, o_err}, 32'd0);
        check("restart_fv", {31'd0, o_fv}, 32'd0);
        check("restart_fvec", {29'd0, o_fvec}, 32'd0);
        check("restart_pass", {31'd0, o_pass}, 32'd0);
        start_a = 1'b0;
      end
      @(negedge clk);
    end
    check("held_two_dones", dcount, 32'd2);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
